vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches have strict priority over CPU accesses.
// Define VRAM_POSTED_WRITE_EN to add a 1-entry posted CPU write buffer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus free, arbitrate video / buffered write / CPU
// VGA_A   | video address presented to RAM
// VGA_D   | video data captured; arbitrates like IDLE for the next access
// CPU_A   | CPU (or buffered) address presented, write strobe retired
// CPU_D   | CPU read data captured, ack pulsed
module vram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_slot,
  input  logic [12:0] vga_addr,
  output logic [7:0]  vga_data,
  output logic        vga_overrun,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VGA_A = 3'd1,
    S_VGA_D = 3'd2,
    S_CPU_A = 3'd3,
    S_CPU_D = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_vga_pend;
  logic [12:0] r_vga_addr;
  logic        r_cur_we;

  logic        w_arb;
  logic        w_vga_go;
  logic        w_cpu_go;
  logic        w_drain_go;
  logic        w_post_take;
  logic [12:0] w_drain_addr;
  logic [7:0]  w_drain_data;

  logic        w_sel_vga;
  logic        w_sel_drain;
  logic        w_sel_cpu;
  logic        w_ram_we_nxt;
  logic [12:0] w_ram_addr_nxt;
  logic [7:0]  w_ram_wdata_nxt;
  logic        w_cpu_ack_nxt;

  // VGA_D frees the RAM port, so it arbitrates like IDLE; a contended CPU access loses only two cycles.
  assign w_arb    = (r_state == S_IDLE) || (r_state == S_VGA_D);
  assign w_vga_go = vga_slot || r_vga_pend;

`ifdef VRAM_POSTED_WRITE_EN
  localparam bit P_POSTED = 1'b1;

  logic        r_wb_valid;
  logic [12:0] r_wb_addr;
  logic [7:0]  r_wb_data;

  assign w_post_take  = cpu_req && cpu_we && !cpu_ack && !r_wb_valid;
  assign w_drain_go   = r_wb_valid;
  assign w_cpu_go     = cpu_req && !cpu_we && !cpu_ack && !r_wb_valid;
  assign w_drain_addr = r_wb_addr;
  assign w_drain_data = r_wb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (w_post_take) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= cpu_addr;
      r_wb_data  <= cpu_wdata;
    end else if (w_sel_drain) begin
      r_wb_valid <= 1'b0;
    end
  end
`else
  localparam bit P_POSTED = 1'b0;

  assign w_post_take  = 1'b0;
  assign w_drain_go   = 1'b0;
  assign w_cpu_go     = cpu_req && !cpu_ack;
  assign w_drain_addr = '0;
  assign w_drain_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_VGA_D: begin
        if (w_vga_go)                     w_next_state = S_VGA_A;
        else if (w_drain_go || w_cpu_go)  w_next_state = S_CPU_A;
        else                              w_next_state = S_IDLE;
      end
      S_VGA_A: w_next_state = S_VGA_D;
      S_CPU_A: w_next_state = r_cur_we ? S_IDLE : S_CPU_D;
      S_CPU_D: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_vga       = w_arb && w_vga_go;
    w_sel_drain     = w_arb && !w_vga_go && w_drain_go;
    w_sel_cpu       = w_arb && !w_vga_go && !w_drain_go && w_cpu_go;
    w_ram_we_nxt    = w_sel_drain || (w_sel_cpu && cpu_we);
    w_ram_addr_nxt  = ram_addr;
    w_ram_wdata_nxt = ram_wdata;
    if (w_sel_vga) begin
      w_ram_addr_nxt = vga_slot ? vga_addr : r_vga_addr;
    end else if (w_sel_drain) begin
      w_ram_addr_nxt  = w_drain_addr;
      w_ram_wdata_nxt = w_drain_data;
    end else if (w_sel_cpu) begin
      w_ram_addr_nxt  = cpu_addr;
      w_ram_wdata_nxt = cpu_wdata;
    end
    // Drained writes were already acked when buffered.
    w_cpu_ack_nxt = w_post_take || (r_state == S_CPU_D) ||
                    ((r_state == S_CPU_A) && r_cur_we && !P_POSTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vga_data    <= '0;
      vga_overrun <= 1'b0;
      r_vga_pend  <= 1'b0;
      r_vga_addr  <= '0;
      r_cur_we    <= 1'b0;
    end else begin
      ram_addr  <= w_ram_addr_nxt;
      ram_we    <= w_ram_we_nxt;
      ram_wdata <= w_ram_wdata_nxt;
      cpu_ack   <= w_cpu_ack_nxt;
      if (w_sel_drain || w_sel_cpu) r_cur_we <= w_ram_we_nxt;
      if (r_state == S_VGA_D) vga_data  <= ram_rdata;
      if (r_state == S_CPU_D) cpu_rdata <= ram_rdata;
      if (vga_slot && r_vga_pend) vga_overrun <= 1'b1;
      if (w_sel_vga) begin
        r_vga_pend <= 1'b0;
      end else if (vga_slot) begin
        r_vga_pend <= 1'b1;
        r_vga_addr <= vga_addr;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized CPU/video
// traffic checked against a behavioural RAM/latency model.
`timescale 1ns/1ps
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_slot;
  logic [12:0] vga_addr;
  logic [7:0]  vga_data;
  logic        vga_overrun;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .vga_slot(vga_slot), .vga_addr(vga_addr), .vga_data(vga_data), .vga_overrun(vga_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Latencies in clock edges, counted from the edge that samples the request.
  localparam int LAT_VGA = 3;
  localparam int LAT_RD  = 3;
  localparam int VGA_BUS = 2;
`ifdef VRAM_POSTED_WRITE_EN
  localparam int LAT_WR  = 1;
`else
  localparam int LAT_WR  = 2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  logic [7:0] exp_vga = 8'h00;

  // Behavioural single-port synchronous RAM with a backdoor preload port.
  logic [7:0]  mem [0:8191];
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  int          we_cnt = 0;
  logic [12:0] last_we_addr = '0;
  logic [7:0]  last_we_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= ram_addr;
      last_we_data <= ram_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bd_write(input logic [12:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vga_slot = 1'b0; vga_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    exp_vga = 8'h00;
  endtask

  task automatic cpu_start(input logic we, input logic [12:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    req_cyc = cyc;
  endtask

  task automatic wait_ack(output int n);
    while (cpu_ack !== 1'b1 && (cyc - req_cyc) < 40) tick();
    n = cyc - req_cyc;
    if (cpu_ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ack_timeout: cpu_ack=%b after %0d edges, expected 1", cpu_ack, n);
    end
  endtask

  task automatic cpu_end();
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_pulse: cpu_ack=%b, expected 0", cpu_ack);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (vga_data    !== 8'h00)  begin errors++; $display("FAIL rst_vga_data: got %h exp 00", vga_data); end
    if (vga_overrun !== 1'b0)   begin errors++; $display("FAIL rst_overrun: got %b exp 0", vga_overrun); end
    if (cpu_ack     !== 1'b0)   begin errors++; $display("FAIL rst_cpu_ack: got %b exp 0", cpu_ack); end
    if (cpu_rdata   !== 8'h00)  begin errors++; $display("FAIL rst_cpu_rdata: got %h exp 00", cpu_rdata); end
    if (ram_addr    !== 13'h0)  begin errors++; $display("FAIL rst_ram_addr: got %h exp 0000", ram_addr); end
    if (ram_we      !== 1'b0)   begin errors++; $display("FAIL rst_ram_we: got %b exp 0", ram_we); end
    if (ram_wdata   !== 8'h00)  begin errors++; $display("FAIL rst_ram_wdata: got %h exp 00", ram_wdata); end
  endtask

  task automatic test_cpu_write_read();
    int n;
    int w0;
    w0 = we_cnt;
    cpu_start(1'b1, 13'h0123, 8'hA5);
    wait_ack(n);
    cpu_end();
    checks++;
    if (n != LAT_WR) begin errors++; $display("FAIL wr_latency: got %0d exp %0d", n, LAT_WR); end
    idle(4);
    checks += 3;
    if (we_cnt - w0 != 1)         begin errors++; $display("FAIL wr_we_pulses: got %0d exp 1", we_cnt - w0); end
    if (last_we_addr !== 13'h0123) begin errors++; $display("FAIL wr_addr: got %h exp 0123", last_we_addr); end
    if (last_we_data !== 8'hA5)    begin errors++; $display("FAIL wr_data: got %h exp a5", last_we_data); end
    cpu_start(1'b0, 13'h0123, 8'h00);
    wait_ack(n);
    checks += 2;
    if (n != LAT_RD)          begin errors++; $display("FAIL rd_latency: got %0d exp %0d", n, LAT_RD); end
    if (cpu_rdata !== 8'hA5)  begin errors++; $display("FAIL rd_data: got %h exp a5", cpu_rdata); end
    cpu_end();
    idle(2);
  endtask

  task automatic test_vga_fetch();
    bd_write(13'h0040, 8'h3C);
    bd_write(13'h1FFF, 8'h77);
    vga_slot = 1'b1; vga_addr = 13'h0040;
    tick();
    vga_slot = 1'b0; vga_addr = 13'h1FFF;
    tick();
    checks++;
    if (vga_data !== exp_vga) begin errors++; $display("FAIL vga_early: got %h exp %h", vga_data, exp_vga); end
    tick();
    checks++;
    if (vga_data !== 8'h3C) begin errors++; $display("FAIL vga_fetch: got %h exp 3c", vga_data); end
    exp_vga = 8'h3C;
    idle(4);
    checks += 2;
    if (vga_data !== 8'h3C)   begin errors++; $display("FAIL vga_hold: got %h exp 3c", vga_data); end
    if (vga_overrun !== 1'b0) begin errors++; $display("FAIL vga_no_overrun: got %b exp 0", vga_overrun); end
  endtask

  task automatic test_contention();
    int n;
    logic [7:0] v_at;
    v_at = 8'h00;
    bd_write(13'h0200, 8'h5A);
    bd_write(13'h0041, 8'h99);
    vga_slot = 1'b1; vga_addr = 13'h0041;
    cpu_start(1'b0, 13'h0200, 8'h00);
    while (cpu_ack !== 1'b1 && (cyc - req_cyc) < 40) begin
      tick();
      vga_slot = 1'b0;
      if (cyc - req_cyc == LAT_VGA) v_at = vga_data;
    end
    n = cyc - req_cyc;
    checks += 3;
    if (n != LAT_RD + VGA_BUS) begin errors++; $display("FAIL cont_latency: got %0d exp %0d", n, LAT_RD + VGA_BUS); end
    if (cpu_rdata !== 8'h5A)   begin errors++; $display("FAIL cont_rdata: got %h exp 5a", cpu_rdata); end
    if (v_at !== 8'h99)        begin errors++; $display("FAIL cont_vga_first: got %h exp 99", v_at); end
    exp_vga = 8'h99;
    cpu_end();
    idle(2);
  endtask

  task automatic test_vga_pend();
    int n;
    int t_ack;
    bd_write(13'h0300, 8'h11);
    bd_write(13'h0050, 8'h22);
    cpu_start(1'b0, 13'h0300, 8'h00);
    tick();
    vga_slot = 1'b1; vga_addr = 13'h0050;
    tick();
    vga_slot = 1'b0; vga_addr = 13'h0000;
    wait_ack(n);
    t_ack = cyc;
    checks += 2;
    if (n != LAT_RD)         begin errors++; $display("FAIL pend_cpu_latency: got %0d exp %0d", n, LAT_RD); end
    if (cpu_rdata !== 8'h11) begin errors++; $display("FAIL pend_cpu_rdata: got %h exp 11", cpu_rdata); end
    cpu_end();
    while (vga_data !== 8'h22 && (cyc - t_ack) < 20) tick();
    checks += 2;
    if (cyc - t_ack != LAT_VGA) begin errors++; $display("FAIL pend_vga_latency: got %0d exp %0d", cyc - t_ack, LAT_VGA); end
    if (vga_overrun !== 1'b0)   begin errors++; $display("FAIL pend_overrun: got %b exp 0", vga_overrun); end
    exp_vga = 8'h22;
    idle(2);
  endtask

  task automatic test_overrun();
    int n;
    int t_ack;
    logic saw_old;
    saw_old = 1'b0;
    bd_write(13'h0301, 8'h33);
    bd_write(13'h0051, 8'h44);
    bd_write(13'h0052, 8'h55);
    cpu_start(1'b0, 13'h0301, 8'h00);
    tick();
    vga_slot = 1'b1; vga_addr = 13'h0051;
    tick();
    vga_addr = 13'h0052;
    tick();
    vga_slot = 1'b0; vga_addr = 13'h0000;
    wait_ack(n);
    t_ack = cyc;
    checks++;
    if (cpu_rdata !== 8'h33) begin errors++; $display("FAIL ovr_cpu_rdata: got %h exp 33", cpu_rdata); end
    cpu_end();
    while (vga_data !== 8'h55 && (cyc - t_ack) < 20) begin
      tick();
      if (vga_data === 8'h44) saw_old = 1'b1;
    end
    checks += 3;
    if (cyc - t_ack != LAT_VGA) begin errors++; $display("FAIL ovr_vga_latency: got %0d exp %0d", cyc - t_ack, LAT_VGA); end
    if (vga_overrun !== 1'b1)   begin errors++; $display("FAIL ovr_flag: got %b exp 1", vga_overrun); end
    if (saw_old !== 1'b0)       begin errors++; $display("FAIL ovr_stale_fetch: got %b exp 0", saw_old); end
    idle(3);
    checks++;
    if (vga_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b exp 1", vga_overrun); end
    do_reset();
    checks++;
    if (vga_overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset_clear: got %b exp 0", vga_overrun); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic ack_seen;
    bd_write(13'h0310, 8'h66);
    cpu_start(1'b1, 13'h0311, 8'h12);
    wait_ack(n);
    cpu_end();
    idle(3);
    vga_slot = 1'b1; vga_addr = 13'h0040;
    tick();
    vga_slot = 1'b0;
    idle(4);
    cpu_start(1'b0, 13'h0310, 8'h00);
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    checks += 7;
    if (cpu_ack   !== 1'b0)  begin errors++; $display("FAIL mid_ack: got %b exp 0", cpu_ack); end
    if (ram_we    !== 1'b0)  begin errors++; $display("FAIL mid_ram_we: got %b exp 0", ram_we); end
    if (ram_addr  !== 13'h0) begin errors++; $display("FAIL mid_ram_addr: got %h exp 0000", ram_addr); end
    if (ram_wdata !== 8'h00) begin errors++; $display("FAIL mid_ram_wdata: got %h exp 00", ram_wdata); end
    if (vga_data  !== 8'h00) begin errors++; $display("FAIL mid_vga_data: got %h exp 00", vga_data); end
    if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL mid_cpu_rdata: got %h exp 00", cpu_rdata); end
    if (vga_overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b exp 0", vga_overrun); end
    reset = 1'b0;
    exp_vga = 8'h00;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack === 1'b1) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen !== 1'b0) begin errors++; $display("FAIL mid_no_ack: got %b exp 0", ack_seen); end
    cpu_start(1'b0, 13'h0311, 8'h00);
    wait_ack(n);
    checks += 2;
    if (n != LAT_RD)         begin errors++; $display("FAIL mid_idle_latency: got %0d exp %0d", n, LAT_RD); end
    if (cpu_rdata !== 8'h12) begin errors++; $display("FAIL mid_idle_rdata: got %h exp 12", cpu_rdata); end
    cpu_end();
    idle(2);
  endtask

  task automatic test_random_cpu();
    logic [7:0] shadow [0:15];
    int n;
    int w0;
    int nwr;
    int idx;
    logic we;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 8'($urandom_range(0, 255));
      bd_write(13'h0800 + 13'(i), shadow[i]);
    end
    w0 = we_cnt;
    nwr = 0;
    for (int k = 0; k < 40; k++) begin
      idx = int'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      cpu_start(we, 13'h0800 + 13'(idx), d);
      wait_ack(n);
      checks++;
      if (we) begin
        if (n != LAT_WR) begin errors++; $display("FAIL rnd_wr_latency[%0d]: got %0d exp %0d", k, n, LAT_WR); end
        shadow[idx] = d;
        nwr++;
      end else begin
        if (n != LAT_RD) begin errors++; $display("FAIL rnd_rd_latency[%0d]: got %0d exp %0d", k, n, LAT_RD); end
        checks++;
        if (cpu_rdata !== shadow[idx]) begin
          errors++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", k, cpu_rdata, shadow[idx]);
        end
      end
      cpu_end();
      idle(3);
    end
    checks++;
    if (we_cnt - w0 != nwr) begin errors++; $display("FAIL rnd_we_count: got %0d exp %0d", we_cnt - w0, nwr); end
  endtask

  task automatic test_random_video();
    logic [12:0] a;
    logic [7:0]  d;
    for (int k = 0; k < 16; k++) begin
      a = 13'h1000 + 13'($urandom_range(0, 4095));
      d = 8'($urandom_range(0, 255));
      bd_write(a, d);
      vga_slot = 1'b1; vga_addr = a;
      tick();
      vga_slot = 1'b0; vga_addr = 13'($urandom_range(0, 8191));
      idle(LAT_VGA - 1);
      checks++;
      if (vga_data !== d) begin errors++; $display("FAIL rnd_vga[%0d]: got %h exp %h", k, vga_data, d); end
      exp_vga = d;
      idle(int'($urandom_range(8, 12)));
    end
    checks++;
    if (vga_overrun !== 1'b0) begin errors++; $display("FAIL rnd_vga_overrun: got %b exp 0", vga_overrun); end
  endtask

`ifdef VRAM_POSTED_WRITE_EN
  task automatic test_posted_write();
    int n;
    logic we_seen;
    logic [7:0] vga_at_we;
    we_seen = 1'b0;
    vga_at_we = 8'h00;
    bd_write(13'h0060, 8'h0F);
    bd_write(13'h0400, 8'h00);
    vga_slot = 1'b1; vga_addr = 13'h0060;
    tick();
    vga_slot = 1'b0;
    cpu_start(1'b1, 13'h0400, 8'hC3);
    while (cpu_ack !== 1'b1 && (cyc - req_cyc) < 40) begin
      tick();
      if (ram_we === 1'b1 && !we_seen) begin we_seen = 1'b1; vga_at_we = vga_data; end
    end
    n = cyc - req_cyc;
    checks++;
    if (n != 1) begin errors++; $display("FAIL post_ack_latency: got %0d exp 1", n); end
    cpu_start(1'b0, 13'h0400, 8'h00);
    while (cpu_ack !== 1'b1 && (cyc - req_cyc) < 40) begin
      tick();
      if (ram_we === 1'b1 && !we_seen) begin we_seen = 1'b1; vga_at_we = vga_data; end
    end
    checks += 3;
    if (we_seen !== 1'b1)     begin errors++; $display("FAIL post_drained: got %b exp 1", we_seen); end
    if (vga_at_we !== 8'h0F)  begin errors++; $display("FAIL post_after_video: got %h exp 0f", vga_at_we); end
    if (cpu_rdata !== 8'hC3)  begin errors++; $display("FAIL post_readback: got %h exp c3", cpu_rdata); end
    cpu_end();
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_write_read();
    test_vga_fetch();
    test_contention();
    test_vga_pend();
    test_overrun();
    test_reset_mid();
    test_random_cpu();
    test_random_video();
`ifdef VRAM_POSTED_WRITE_EN
    test_posted_write();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
